pin_array_deser: RTL
====================

# pin_array_deser

Serial-to-parallel receiver for the pin-array bus: collects single-bit `vin` samples into `WIDTH`-bit words and presents them on `mid` with a valid/ready handshake. It is the receiving end of the `pin_array_0_1` path, which collapses a `mid[3:0]` bus onto one line. It rebuilds that bus so downstream `pin_array_0`-style consumers see parallel data again. A 2-entry output buffer absorbs short downstream stalls.

## Interface
Parameters:
- `WIDTH`, 4, word width in bits; legal range 2..16.
- `MSB_FIRST`, 1, 1 = first received bit lands in `mid[WIDTH-1]`; 0 = first bit lands in `mid[0]`.

Ports:
- Clock and reset: one clock, `clk`; reset `rstb` is synchronous and active-low.
- `clk`  input  1  sole clock, rising edge.
- `rstb`  input  1  synchronous active-low reset.
- `VDD`  input  1  supply pin; no logic function.
- `VSS`  input  1  supply pin; no logic function.
- `vin`  input  1  serial data bit.
- `vin_valid`  input  1  `vin` is sampled this cycle.
- `sync`  input  1  frame-align; restarts word assembly.
- `mid`  output  WIDTH  head word of the output buffer.
- `mid_valid`  output  1  `mid` holds a valid word.
- `mid_ready`  input  1  downstream accepts `mid` this cycle.
- `overflow`  output  1  sticky; a completed word was dropped.

## Operation
- Assembly register `shreg[WIDTH-1:0]` and bit counter `cnt` (0..WIDTH-1, width `$clog2(WIDTH)`).
- `vin_valid`=1: `vin` is written to position `cnt` (MSB_FIRST: position WIDTH-1-cnt), then `cnt` increments.
- When `cnt`=WIDTH-1 and `vin_valid`=1, the word completes. The completed word (including the current bit) is pushed into the buffer and `cnt` wraps to 0.
- `sync`=1: any partial word is discarded and `cnt` is forced to 0 before the same cycle's bit is applied. If `vin_valid`=1 in the same cycle, that bit becomes bit 0 of the new word.
- Buffer: 2-entry FIFO with head and tail pointers (1 bit each) and a count of 0..2. `mid` is the head entry; `mid_valid` = (count≠0).
- A pop happens when `mid_valid && mid_ready`.
- Push when full:
  - If a pop also occurs that cycle, the push is accepted and count stays 2.
  - Otherwise the word is dropped, count is unchanged, and `overflow` is set to 1.
- `overflow` clears only on reset.
- `mid` is held stable while `mid_valid`=1 and `mid_ready`=0.
- Reset values: `cnt`=0, `shreg`=0, buffer empty, `mid`=0, `mid_valid`=0, `overflow`=0.
- `rstb`=0 mid-word or with a full buffer: the partial word and all buffered words are discarded. No output asserts in the reset cycle or the cycle after it.

## Timing
- Latency: last bit sampled at edge N → `mid_valid`=1 after edge N, so it is visible in cycle N+1. The word is not visible combinationally.
- Throughput: one bit per cycle, giving one word per WIDTH cycles. The buffer never fills if `mid_ready` stalls for fewer than WIDTH cycles.
- All outputs are registered. There is no combinational path from `mid_ready` to `mid_valid` or to `mid`.
- `sync`, `vin`, `vin_valid` and `mid_ready` are sampled only on rising `clk`.

## Structure
- Shared package `pin_array_pkg`:
  - `PA_WIDTH_DEFAULT`=4.
  - `typedef logic [PA_WIDTH_DEFAULT-1:0] pa_word_t`.
  - `PA_FIFO_DEPTH`=2.
- Sub-module `pin_array_fifo2`: the 2-entry FIFO, with push/pop/full/empty/count outputs. It is instantiated once. Word assembly stays in the top module.

## Test plan
- Basic assembly: WIDTH=4, MSB_FIRST=1, stream 1,0,1,1 with `vin_valid`=1 and `mid_ready`=1 → `mid`=4'b1011, `mid_valid`=1 for exactly one cycle, starting one cycle after the 4th bit.
- Bit ordering: MSB_FIRST=0, same stream 1,0,1,1 → `mid`=4'b1101.
- Sync mid-word: send 1,1; then `sync`=1 with `vin`=0; then 0,1,0 → `mid`=4'b0010. The partial bits 1,1 never appear on `mid`.
- Overflow: `mid_ready`=0, send 12 bits of words 0xA, 0x5, 0x3 → buffer holds 0xA then 0x5, and `overflow`=1 after the 12th bit. Then `mid_ready`=1 → `mid` shows 0xA then 0x5, then `mid_valid`=0.
- Simultaneous push and pop when full: buffer full with 0xA, 0x5, and `mid_ready`=1 in the cycle word 0x3 completes → `overflow` stays 0 and the output sequence is 0xA, 0x5, 0x3.
- Reset mid-operation: `rstb`=0 for 1 cycle after 2 bits, with one word buffered → next cycle `mid_valid`=0, `mid`=0, `overflow`=0. The next 4 bits 0,1,1,0 → `mid`=4'b0110.

Source files
------------

// File: rtl/pin_array_pkg.sv
// Shared definitions for the pin-array serial path: default word width,
// output buffer depth and the bit-placement rule used during word assembly.
package pin_array_pkg;

    localparam int PA_WIDTH_DEFAULT = 4;
    localparam int PA_FIFO_DEPTH    = 2;

    typedef logic [PA_WIDTH_DEFAULT-1:0] pa_word_t;

    // Bit index that the cnt-th received bit of a word occupies.
    function automatic int pa_bit_pos(input int cnt, input int width, input bit msb_first);
        return msb_first ? (width - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/pin_array_fifo2.sv
// Two-entry output buffer for assembled words. A push into a full buffer is
// still accepted when a pop frees the head in the same cycle.
module pin_array_fifo2
    import pin_array_pkg::*;
#(
    parameter int WIDTH = PA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count,
    output logic             drop
);

    logic [PA_FIFO_DEPTH-1:0][WIDTH-1:0] mem;
    logic                                head;
    logic                                tail;
    logic                                pop_ok;
    logic                                push_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;
    assign dout    = mem[head];

    always_ff @(posedge clk) begin
        if (!rstb) begin
            mem   <= '0;
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[tail] <= din;
                tail      <= ~tail;
            end
            if (pop_ok) begin
                head <= ~head;
            end
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

endmodule

// File: rtl/pin_array_deser.sv
// Serial-to-parallel receiver: packs vin samples into WIDTH-bit words and
// hands them downstream through a 2-entry valid/ready buffer.
module pin_array_deser
    import pin_array_pkg::*;
#(
    parameter int WIDTH     = PA_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             VDD,
    input  logic             VSS,
    input  logic             vin,
    input  logic             vin_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] mid,
    output logic             mid_valid,
    input  logic             mid_ready,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_base;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_nxt;
    logic [WIDTH-1:0] shreg_nxt;
    logic             word_done;

    logic             fifo_full;
    logic             fifo_empty;
    logic [1:0]       fifo_count;
    logic             fifo_drop;
    logic             unused_sig;

    // sync discards the partial word before this cycle's bit is placed,
    // so a bit arriving with sync becomes bit 0 of the fresh word.
    always_comb begin
        cnt_base  = sync ? '0 : cnt;
        word_nxt  = sync ? '0 : shreg;
        for (int i = 0; i < WIDTH; i++) begin
            if (vin_valid && (i == pa_bit_pos(int'(cnt_base), WIDTH, MSB_FIRST))) begin
                word_nxt[i] = vin;
            end
        end
        word_done = vin_valid && (cnt_base == CW'(WIDTH - 1));
        cnt_nxt   = cnt_base;
        shreg_nxt = word_nxt;
        if (vin_valid) begin
            cnt_nxt = word_done ? '0 : cnt_base + CW'(1);
        end
        if (word_done) begin
            shreg_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            cnt      <= '0;
            shreg    <= '0;
            overflow <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            if (fifo_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    pin_array_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rstb  (rstb),
        .push  (word_done),
        .din   (word_nxt),
        .pop   (mid_ready),
        .dout  (mid),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    assign mid_valid = ~fifo_empty;

    // Supply pins carry no logic; fold them with the spare buffer status.
    assign unused_sig = ^{VDD, VSS, fifo_full, fifo_count};

endmodule
